synthesizer_input_sequencer: RTL
================================

# synthesizer_input_sequencer

Transmit-side source for the synthesizer's channelized input stream. Holds one complex sample per channel in a ping-pong (double-buffered) channel memory loaded by a sparse write port. Once per frame period it emits a burst of exactly NUM_CHANNELS samples in ascending channel order, so a synthesizer can be driven with synthetic per-channel content instead of channelizer output. Bank swaps are atomic at frame boundaries, so a burst never mixes old and new content.

## Interface
- NUM_CHANNELS, 16: channels per frame; power of 2, 4..64.
- DATA_WIDTH, 20: signed I/Q width; matches the channelizer output width for 16 channels.
- FRAME_PERIOD, 64: cycles between burst starts; must be >= NUM_CHANNELS + 2.

- Clk  in  1: clock.
- Rst  in  1: reset, synchronous, active-low; clock Clk.
- Enable  in  1: frame generation enable.
- Input_valid  in  1: write strobe into the inactive (write) bank.
- Input_index  in  $clog2(NUM_CHANNELS): channel written.
- Input_data  in  2 x DATA_WIDTH signed: [0]=I, [1]=Q.
- Input_commit  in  1: request a bank swap at the next frame boundary.
- Output_valid  out  1: sample strobe.
- Output_index  out  $clog2(NUM_CHANNELS): channel of the current sample.
- Output_last  out  1: high with index NUM_CHANNELS-1.
- Output_data  out  2 x DATA_WIDTH signed: [0]=I, [1]=Q.
- Status_read_bank  out  1: bank currently being emitted.
- Error_commit_overlap  out  1: one-cycle pulse.

## Operation
- **Storage:** two banks of NUM_CHANNELS x 2 x DATA_WIDTH, plus one written-flag per bank per channel.
  - Reset clears all flags only; data RAM contents are not reset.
  - Any channel whose flag is clear is emitted as I=Q=0.
- **Writes:** Input_valid=1 writes Input_data to bank ~read_bank at Input_index and sets that channel's flag. A repeated write to the same index overwrites; the last write wins.
- **Frame timer t:** range 0..FRAME_PERIOD-1.
  - While Enable=0 and t=0, t holds at 0 and no burst starts.
  - A burst starts on any cycle with t=0 and Enable=1; t then advances every cycle and wraps to 0.
  - Deasserting Enable mid-frame does not abort anything: the current burst completes, t runs to wrap, then holds at 0.
- **Commit:**
  - Input_commit sets commit_pending.
  - At a burst start with commit_pending=1, read_bank toggles and commit_pending clears in the same cycle. That burst reads the new bank.
  - Input_commit while commit_pending=1 pulses Error_commit_overlap the next cycle; the pending request is kept, not doubled.
  - If Input_commit coincides with a burst-start cycle, the commit is not applied to that burst; it becomes pending for the next one.
  - After a swap, the write bank holds the previous read-bank content. Writes are incremental on top of that content.
- **Read/write same-cycle hazard:** impossible by construction, since reads and writes always target different banks.
- **States:**
  - IDLE: t=0 and Enable=0.
  - BURST: t in 0..NUM_CHANNELS-1; a read is issued with address t.
  - GAP: the remaining cycles of the frame.
  - Transitions are implied entirely by t and Enable.

## Timing
- **Reset values:** Output_valid=0, Output_index=0, Output_last=0, Output_data=0, Status_read_bank=0, Error_commit_overlap=0, commit_pending=0, t=0.
- **Output latency:** read address issued at t=k; RAM read is 1 cycle, output register 1 cycle. Output_valid is high for exactly NUM_CHANNELS consecutive cycles, t=2..NUM_CHANNELS+1, carrying Output_index=t-2.
- **Idle outputs:** when Output_valid=0, Output_data and Output_index are driven 0 and Output_last=0.
- **Status_read_bank:** updates on the cycle after the swap cycle.
- **Burst spacing:** consecutive bursts are spaced exactly FRAME_PERIOD cycles apart while Enable stays 1.
- **Throughput:** the write port accepts one write per cycle with no backpressure.
- **Reset mid-burst:** Rst=0 at any point makes outputs 0 the next cycle. The burst is dropped with no partial completion, and flags are cleared.

## Test plan
- **Reset/idle:** hold Rst=0 for 10 cycles, then release with Enable=0 for 200 cycles -> Output_valid never asserts; all outputs are 0.
- **Zero fill:** Enable=1 with nothing written -> 16 valid cycles at t=2..17, indices 0..15, I=Q=0, Output_last only on index 15; next burst starts 64 cycles later.
- **Load and commit:** write channel k with I=k*100, Q=-k, then commit -> next burst emits those values in order with Status_read_bank=1. Then write only ch3 with I=7 and commit -> ch3 emits 7; every other channel emits zero, because the new bank contains only the ch3 write.
- **Atomic swap:** issue commit at t=5 during a burst -> that burst stays entirely on the old bank; the new values first appear in the following burst.
- **Overlap:** two commits 3 cycles apart inside one frame -> one Error_commit_overlap pulse and exactly one bank toggle. A commit on the burst-start cycle itself is deferred to the next burst.
- **Enable/reset mid-burst:** drop Enable at t=8 -> indices 0..15 still complete, then no further bursts. Assert Rst at t=8 -> Output_valid is 0 from the next cycle and the flags read back as zero after re-enable.

Source files
------------

// File: rtl/synthesizer_input_sequencer.sv
// Ping-pong channel memory that replays one complex sample per channel as a burst
// once per frame; bank swaps requested by Input_commit take effect at burst starts.
module synthesizer_input_sequencer #(
  parameter int NUM_CHANNELS = 16,
  parameter int DATA_WIDTH   = 20,
  parameter int FRAME_PERIOD = 64
) (
  input  logic                                   Clk,
  input  logic                                   Rst,
  input  logic                                   Enable,
  input  logic                                   Input_valid,
  input  logic [$clog2(NUM_CHANNELS)-1:0]        Input_index,
  input  logic signed [1:0][DATA_WIDTH-1:0]      Input_data,
  input  logic                                   Input_commit,
  output logic                                   Output_valid,
  output logic [$clog2(NUM_CHANNELS)-1:0]        Output_index,
  output logic                                   Output_last,
  output logic signed [1:0][DATA_WIDTH-1:0]      Output_data,
  output logic                                   Status_read_bank,
  output logic                                   Error_commit_overlap
);

  localparam int IW = $clog2(NUM_CHANNELS);
  localparam int TW = $clog2(FRAME_PERIOD);
  localparam int AW = IW + 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   t_reg, t_next;
  logic            rd_en;
  logic            burst_start;
  logic            swap;
  logic            rd_bank, wr_bank;
  logic [AW-1:0]   rd_addr, wr_addr;

  logic            read_bank_reg;
  logic            commit_pending_reg;
  logic            err_reg;

  logic [2*DATA_WIDTH-1:0] mem [2*NUM_CHANNELS];
  logic [2*NUM_CHANNELS-1:0] flag_reg;

  logic [2*DATA_WIDTH-1:0]        rd_data_reg;
  logic                           rd_flag_reg;
  logic                           rd_valid_reg;
  logic [IW-1:0]                  rd_index_reg;
  logic [1:0][DATA_WIDTH-1:0]     rd_lanes;
  logic [1:0][DATA_WIDTH-1:0]     gated_lanes;

  logic                           out_valid_reg;
  logic [IW-1:0]                  out_index_reg;
  logic                           out_last_reg;
  logic [1:0][DATA_WIDTH-1:0]     out_data_reg;

  // IDLE doubles as the t=0 slot: a burst starts there whenever Enable is high.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_reg <= S_IDLE;
      t_reg     <= '0;
    end else begin
      state_reg <= state_next;
      t_reg     <= t_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    rd_en      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (Enable) begin
          rd_en      = 1'b1;
          t_next     = TW'(1);
          state_next = S_BURST;
        end
      end
      S_BURST: begin
        rd_en  = 1'b1;
        t_next = t_reg + TW'(1);
        if (t_reg == TW'(NUM_CHANNELS - 1)) state_next = S_GAP;
      end
      S_GAP: begin
        if (t_reg == TW'(FRAME_PERIOD - 1)) begin
          t_next     = '0;
          state_next = S_IDLE;
        end else begin
          t_next = t_reg + TW'(1);
        end
      end
      default: begin
        t_next     = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // The swapping burst already reads the new bank, and writes follow the bank
  // that is not being read, so the two ports never collide.
  assign burst_start = (state_reg == S_IDLE) && Enable;
  assign swap        = burst_start && commit_pending_reg;
  assign rd_bank     = read_bank_reg ^ swap;
  assign wr_bank     = ~rd_bank;
  assign rd_addr     = {rd_bank, IW'(t_reg)};
  assign wr_addr     = {wr_bank, Input_index};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      read_bank_reg      <= 1'b0;
      commit_pending_reg <= 1'b0;
      err_reg            <= 1'b0;
    end else begin
      read_bank_reg      <= rd_bank;
      commit_pending_reg <= swap ? Input_commit : (commit_pending_reg | Input_commit);
      err_reg            <= Input_commit && commit_pending_reg && !swap;
    end
  end

  always_ff @(posedge Clk) begin
    if (Input_valid) mem[wr_addr] <= Input_data;
    rd_data_reg <= mem[rd_addr];
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      flag_reg     <= '0;
      rd_flag_reg  <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_index_reg <= '0;
    end else begin
      if (Input_valid) flag_reg[wr_addr] <= 1'b1;
      rd_flag_reg  <= flag_reg[rd_addr];
      rd_valid_reg <= rd_en;
      rd_index_reg <= IW'(t_reg);
    end
  end

  assign rd_lanes = rd_data_reg;

  // Never-written channels read as zero regardless of stale RAM content.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_lane
    assign gated_lanes[gi] = rd_flag_reg ? rd_lanes[gi] : '0;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      out_valid_reg <= 1'b0;
      out_index_reg <= '0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= rd_valid_reg;
      out_index_reg <= rd_valid_reg ? rd_index_reg : '0;
      out_last_reg  <= rd_valid_reg && (rd_index_reg == IW'(NUM_CHANNELS - 1));
      out_data_reg  <= rd_valid_reg ? gated_lanes : '0;
    end
  end

  assign Output_valid         = out_valid_reg;
  assign Output_index         = out_index_reg;
  assign Output_last          = out_last_reg;
  assign Output_data          = out_data_reg;
  assign Status_read_bank     = read_bank_reg;
  assign Error_commit_overlap = err_reg;

endmodule
